cs_decode_sched: RTL and testbench

Generation scheduler for the (2,3) cyclic-shift MDS decoder. It takes coded symbols from the link one at a time, each tagged with a generation id and a symbol index, and assembles them into one 3-symbol codeword per generation. It closes a generation when it is complete, when both systematic symbols are present, on timeout, or when the next generation starts. It then issues the codeword with an erasure mask to the decoder, captures the result and presents it on a valid/ready output.

---
 rtl/cs_decode_sched.sv | 212 +++++++++++++++++++++
 tb/tb_cs_decode_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_decode_sched.sv
// cs_decode_sched
// Generation scheduler for the (2,3) cyclic-shift MDS decoder. Collects
// tagged coded symbols into one 3-symbol codeword per generation, closes the
// generation (complete, both systematic symbols held, timeout, or a new
// generation arriving), issues the codeword plus erasure mask to the decoder,
// captures the decoder result and presents it on a valid/ready output.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   sym_valid/sym_ready         input symbol handshake
//   sym_idx, sym_gen, sym_data  symbol index (0,1 data, 2 parity, 3 illegal),
//                               generation id, payload
//   dec_valid_in, dec_erasure,
//   dec_coded_0..2              codeword towards the decoder
//   dec_valid_out, dec_ok,
//   dec_data_0/1                result from the decoder
//   out_valid/out_ready         result handshake
//   out_ok, out_gen, out_erasure,
//   out_data_0/1                captured result
//   stale_drop, dup_drop,
//   bad_idx                     one-cycle drop pulses, cycle after the accept
module cs_decode_sched #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned GEN_W     = 8,
    parameter int unsigned TIMEOUT   = 16,
    parameter bit          EARLY_SYS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [1:0]       sym_idx,
    input  logic [GEN_W-1:0] sym_gen,
    input  logic [WIDTH-1:0] sym_data,
    output logic             dec_valid_in,
    output logic [2:0]       dec_erasure,
    output logic [WIDTH-1:0] dec_coded_0,
    output logic [WIDTH-1:0] dec_coded_1,
    output logic [WIDTH-1:0] dec_coded_2,
    input  logic             dec_valid_out,
    input  logic             dec_ok,
    input  logic [WIDTH-1:0] dec_data_0,
    input  logic [WIDTH-1:0] dec_data_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ok,
    output logic [GEN_W-1:0] out_gen,
    output logic [2:0]       out_erasure,
    output logic [WIDTH-1:0] out_data_0,
    output logic [WIDTH-1:0] out_data_1,
    output logic             stale_drop,
    output logic             dup_drop,
    output logic             bad_idx
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] buf0, buf1, buf2;
    logic [2:0]       rx;
    logic [GEN_W-1:0] cur_gen, last_gen;
    logic             last_v;
    logic [CNT_W-1:0] cnt;

    logic       accept, is_bad, is_stale, is_dup, store, foreign, close;
    logic [2:0] idx_hot, rx_base, rx_new;

    // Symbol classification and close condition
    always_comb begin
        idx_hot = '0;
        case (sym_idx)
            2'd0:    idx_hot = 3'b001;
            2'd1:    idx_hot = 3'b010;
            2'd2:    idx_hot = 3'b100;
            default: idx_hot = '0;
        endcase
        // A new generation always starts from an empty mask
        rx_base  = (state == S_IDLE) ? '0 : rx;
        accept   = sym_valid && sym_ready;
        is_bad   = (sym_idx == 2'd3);
        is_stale = last_v && (sym_gen == last_gen);
        is_dup   = |(rx_base & idx_hot);
        store    = accept && !is_bad && !is_stale && !is_dup;
        rx_new   = rx_base | (store ? idx_hot : 3'b000);
        foreign  = sym_valid && (sym_gen != cur_gen) && !is_stale;
        close    = (state == S_COLLECT) &&
                   ((rx_new == 3'b111) ||
                    (EARLY_SYS && (rx_new[1:0] == 2'b11)) ||
                    (cnt == CNT_W'(TIMEOUT - 1)) ||
                    foreign);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (store)         state_nx = S_COLLECT;
            S_COLLECT: if (close)         state_nx = S_ISSUE;
            S_ISSUE:                      state_nx = S_WAIT;
            S_WAIT:    if (dec_valid_out) state_nx = S_OUTPUT;
            S_OUTPUT:  if (out_ready)     state_nx = S_IDLE;
            default:                      state_nx = S_IDLE;
        endcase
    end

    // Outputs; the codeword is held through WAIT because the decoder result
    // is combinational from these lanes.
    always_comb begin
        sym_ready    = 1'b0;
        dec_valid_in = 1'b0;
        dec_erasure  = '0;
        dec_coded_0  = '0;
        dec_coded_1  = '0;
        dec_coded_2  = '0;
        out_valid    = 1'b0;
        case (state)
            S_IDLE:    sym_ready = rst_n;
            S_COLLECT: sym_ready = !sym_valid || (sym_gen == cur_gen) || is_stale;
            default:   sym_ready = 1'b0;
        endcase
        if (state == S_ISSUE || state == S_WAIT) begin
            dec_valid_in = (state == S_ISSUE);
            dec_erasure  = ~rx;
            dec_coded_0  = rx[0] ? buf0 : '0;
            dec_coded_1  = rx[1] ? buf1 : '0;
            dec_coded_2  = rx[2] ? buf2 : '0;
        end
        out_valid = (state == S_OUTPUT);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf0        <= '0;
            buf1        <= '0;
            buf2        <= '0;
            rx          <= '0;
            cur_gen     <= '0;
            last_gen    <= '0;
            last_v      <= 1'b0;
            cnt         <= '0;
            out_ok      <= 1'b0;
            out_gen     <= '0;
            out_erasure <= '0;
            out_data_0  <= '0;
            out_data_1  <= '0;
            stale_drop  <= 1'b0;
            dup_drop    <= 1'b0;
            bad_idx     <= 1'b0;
        end else begin
            bad_idx    <= accept && is_bad;
            stale_drop <= accept && !is_bad && is_stale;
            dup_drop   <= accept && !is_bad && !is_stale && is_dup;

            if (store) begin
                case (sym_idx)
                    2'd0:    buf0 <= sym_data;
                    2'd1:    buf1 <= sym_data;
                    2'd2:    buf2 <= sym_data;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (store) begin
                        cur_gen <= sym_gen;
                        rx      <= rx_new;
                        cnt     <= '0;
                    end
                end
                S_COLLECT: begin
                    rx  <= rx_new;
                    cnt <= cnt + 1'b1;
                    if (close) begin
                        last_gen <= cur_gen;
                        last_v   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (dec_valid_out) begin
                        out_ok      <= dec_ok;
                        out_gen     <= cur_gen;
                        out_erasure <= ~rx;
                        out_data_0  <= dec_data_0;
                        out_data_1  <= dec_data_1;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) rx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cs_decode_sched.sv
// Testbench for cs_decode_sched: directed steps followed by randomized
// generations, each checked against an expectation derived from which
// symbols were delivered (erasure mask, recoverability, original payloads).
// A small behavioural decoder stands in for the MDS decoder.
module tb_cs_decode_sched;

    localparam int W  = 4;
    localparam int G  = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, sym_valid, sym_ready;
    logic [1:0]   sym_idx;
    logic [G-1:0] sym_gen;
    logic [W-1:0] sym_data;
    logic         dec_valid_in, dec_valid_out, dec_ok;
    logic [2:0]   dec_erasure;
    logic [W-1:0] dec_coded_0, dec_coded_1, dec_coded_2, dec_data_0, dec_data_1;
    logic         out_valid, out_ready, out_ok;
    logic [G-1:0] out_gen;
    logic [2:0]   out_erasure;
    logic [W-1:0] out_data_0, out_data_1;
    logic         stale_drop, dup_drop, bad_idx;

    int checks = 0, errors = 0, issues = 0, closes = 0;

    cs_decode_sched #(.WIDTH(W), .GEN_W(G), .TIMEOUT(TO), .EARLY_SYS(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_idx(sym_idx),
        .sym_gen(sym_gen), .sym_data(sym_data),
        .dec_valid_in(dec_valid_in), .dec_erasure(dec_erasure),
        .dec_coded_0(dec_coded_0), .dec_coded_1(dec_coded_1), .dec_coded_2(dec_coded_2),
        .dec_valid_out(dec_valid_out), .dec_ok(dec_ok),
        .dec_data_0(dec_data_0), .dec_data_1(dec_data_1),
        .out_valid(out_valid), .out_ready(out_ready), .out_ok(out_ok),
        .out_gen(out_gen), .out_erasure(out_erasure),
        .out_data_0(out_data_0), .out_data_1(out_data_1),
        .stale_drop(stale_drop), .dup_drop(dup_drop), .bad_idx(bad_idx)
    );

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v);
        return {v[W-2:0], v[W-1]};
    endfunction
    function automatic logic [W-1:0] rotr(input logic [W-1:0] v);
        return {v[0], v[W-1:1]};
    endfunction
    function automatic logic [W-1:0] par(input logic [W-1:0] d0, input logic [W-1:0] d1);
        return d0 ^ rotl(d1);
    endfunction

    // Decoder stand-in: one-cycle valid latency, data combinational from lanes
    always_ff @(posedge clk) begin
        if (!rst_n) dec_valid_out <= 1'b0;
        else        dec_valid_out <= dec_valid_in;
    end
    always_comb begin
        dec_ok     = 1'b0;
        dec_data_0 = '0;
        dec_data_1 = '0;
        case (dec_erasure)
            3'b000, 3'b100: begin dec_ok = 1'b1; dec_data_0 = dec_coded_0; dec_data_1 = dec_coded_1; end
            3'b001: begin dec_ok = 1'b1; dec_data_1 = dec_coded_1; dec_data_0 = dec_coded_2 ^ rotl(dec_coded_1); end
            3'b010: begin dec_ok = 1'b1; dec_data_0 = dec_coded_0; dec_data_1 = rotr(dec_coded_2 ^ dec_coded_0); end
            default: ;
        endcase
    end

    always @(negedge clk) if (rst_n && dec_valid_in) issues++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Present one symbol and hold it until accepted (bounded)
    task automatic send(input logic [1:0] idx, input logic [G-1:0] g, input logic [W-1:0] d);
        sym_valid = 1'b1; sym_idx = idx; sym_gen = g; sym_data = d;
        #1;
        for (int i = 0; i < 40 && !sym_ready; i++) cyc();
        check("send_ready", sym_ready, 1'b1);
        cyc();
        sym_valid = 1'b0;
    endtask

    // Wait (bounded) for a result and compare every field
    task automatic wait_out(input string tag, input logic [G-1:0] g, input logic [2:0] era,
                            input logic ok, input logic [W-1:0] d0, input logic [W-1:0] d1,
                            output int lat);
        bit found = 0;
        lat = -1;
        closes++;
        for (int i = 0; i < 60; i++) begin
            smp();
            if (out_valid) begin found = 1; lat = i; break; end
        end
        check({tag, "_found"}, found, 1'b1);
        check({tag, "_gen"}, out_gen, g);
        check({tag, "_erasure"}, out_erasure, era);
        check({tag, "_ok"}, out_ok, ok);
        check({tag, "_data"}, {out_data_0, out_data_1}, {d0, d1});
    endtask

    // Reference: result follows from which symbols were delivered
    task automatic expect_gen(input string tag, input logic [G-1:0] g, input logic [2:0] present,
                              input logic [W-1:0] d0, input logic [W-1:0] d1);
        logic [2:0] era;
        logic       ok;
        int         lat;
        era = ~present;
        ok  = ($countones(era) <= 1);
        wait_out(tag, g, era, ok, ok ? d0 : '0, ok ? d1 : '0, lat);
    endtask

    logic [63:0] all_out;
    assign all_out = {sym_ready, dec_valid_in, dec_erasure, dec_coded_0, dec_coded_1, dec_coded_2,
                      out_valid, out_ok, out_gen, out_erasure, out_data_0, out_data_1,
                      stale_drop, dup_drop, bad_idx};

    initial begin
        logic [W-1:0] a, b, x0;
        logic [2:0]   mask;
        logic [1:0]   ord [3];
        bit           early;
        int           lat, r;

        rst_n = 1'b0; sym_valid = 1'b0; sym_idx = '0; sym_gen = '0; sym_data = '0; out_ready = 1'b1;
        repeat (3) cyc();
        smp();
        check("reset_outputs", all_out, 64'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("idle_ready", sym_ready, 1'b1);

        // Complete generation, exact latency
        send(2'd0, 8'd5, 4'h3);
        send(2'd2, 8'd5, par(4'h3, 4'h9));
        send(2'd1, 8'd5, 4'h9);
        smp();
        check("g5_issue", {dec_valid_in, dec_erasure, out_valid}, {1'b1, 3'b000, 1'b0});
        check("g5_coded", {dec_coded_0, dec_coded_1, dec_coded_2}, {4'h3, 4'h9, par(4'h3, 4'h9)});
        cyc(); smp();
        check("g5_wait", {dec_valid_in, out_valid, sym_ready}, 3'b000);
        cyc();
        wait_out("g5", 8'd5, 3'b000, 1'b1, 4'h3, 4'h9, lat);
        check("g5_latency", lat, 0);
        cyc();

        // Timeout with data_0 erased
        x0 = 4'(($urandom));
        send(2'd1, 8'd7, 4'hA);
        send(2'd2, 8'd7, par(x0, 4'hA));
        early = 0;
        for (int i = 0; i < TO - 1; i++) begin smp(); early |= dec_valid_in; cyc(); end
        check("g7_no_early_issue", early, 1'b0);
        smp();
        check("g7_issue_at_timeout", {dec_valid_in, dec_erasure}, {1'b1, 3'b001});
        expect_gen("g7", 8'd7, 3'b110, x0, 4'hA);
        cyc();

        // Timeout with two erasures
        send(2'd0, 8'd8, 4'h6);
        expect_gen("g8", 8'd8, 3'b001, 4'h6, 4'h0);
        cyc();

        // Next generation closes the current one and stalls until IDLE
        send(2'd0, 8'd9, 4'h2);
        sym_valid = 1'b1; sym_idx = 2'd1; sym_gen = 8'd10; sym_data = 4'hC;
        #1;
        check("g10_stalled", sym_ready, 1'b0);
        expect_gen("g9", 8'd9, 3'b001, 4'h2, 4'h0);
        check("g10_still_stalled", sym_ready, 1'b0);
        cyc();
        check("g10_ready_idle", sym_ready, 1'b1);
        cyc();
        sym_valid = 1'b0;
        send(2'd0, 8'd10, 4'h5);
        send(2'd2, 8'd10, par(4'h5, 4'hC));
        expect_gen("g10", 8'd10, 3'b111, 4'h5, 4'hC);
        cyc();

        // Drop pulses
        a = 4'hB; b = 4'h4;
        send(2'd0, 8'd3, a);
        send(2'd0, 8'd3, b);
        smp(); check("dup_pulse", {stale_drop, dup_drop, bad_idx}, 3'b010);
        cyc(); smp(); check("dup_pulse_end", {stale_drop, dup_drop, bad_idx}, 3'b000);
        cyc();
        send(2'd3, 8'd3, 4'h1);
        smp(); check("bad_pulse", {stale_drop, dup_drop, bad_idx}, 3'b001);
        cyc();
        send(2'd1, 8'd3, 4'h7);
        send(2'd2, 8'd3, par(a, 4'h7));
        expect_gen("g3", 8'd3, 3'b111, a, 4'h7);
        cyc();
        send(2'd2, 8'd3, 4'hF);
        smp(); check("stale_pulse", {stale_drop, dup_drop, bad_idx, sym_ready, dec_valid_in}, 5'b10010);
        cyc(); smp(); check("stale_pulse_end", {stale_drop, dup_drop, bad_idx}, 3'b000);
        cyc();

        // Output stall, then reset during COLLECT
        out_ready = 1'b0;
        send(2'd0, 8'd20, 4'hE);
        send(2'd1, 8'd20, 4'h1);
        send(2'd2, 8'd20, par(4'hE, 4'h1));
        expect_gen("g20_stall", 8'd20, 3'b111, 4'hE, 4'h1);
        for (int i = 0; i < 10; i++) begin
            cyc(); smp();
            check("stall_hold", {out_valid, out_ok, out_gen, out_erasure, out_data_0, out_data_1},
                  {1'b1, 1'b1, 8'd20, 3'b000, 4'hE, 4'h1});
        end
        cyc();
        out_ready = 1'b1;
        cyc(); smp();
        check("stall_release", {out_valid, sym_ready}, 2'b01);
        cyc();
        send(2'd0, 8'd21, 4'h9);
        send(2'd1, 8'd21, 4'h8);
        rst_n = 1'b0;
        cyc(); cyc(); smp();
        check("midrun_reset", all_out, 64'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", sym_ready, 1'b1);
        send(2'd0, 8'd20, 4'h3);
        send(2'd1, 8'd20, 4'hD);
        send(2'd2, 8'd20, par(4'h3, 4'hD));
        expect_gen("g20_fresh", 8'd20, 3'b111, 4'h3, 4'hD);
        cyc();

        // Randomized generations
        for (int k = 0; k < 20; k++) begin
            logic [G-1:0] g;
            bit           first;
            g    = G'(100 + k);
            mask = 3'($urandom_range(1, 7));
            a    = 4'($urandom);
            b    = 4'($urandom);
            r    = $urandom_range(0, 2);
            for (int j = 0; j < 3; j++) ord[j] = 2'((r + j) % 3);
            first = 1;
            for (int j = 0; j < 3; j++) begin
                if (mask[ord[j]]) begin
                    repeat ($urandom_range(0, 2)) cyc();
                    case (ord[j])
                        2'd0:    send(2'd0, g, a);
                        2'd1:    send(2'd1, g, b);
                        default: send(2'd2, g, par(a, b));
                    endcase
                    if (first && $urandom_range(0, 3) == 0) send(ord[j], g, ~a ^ b);
                    first = 0;
                end
            end
            expect_gen("rand", g, mask, a, b);
            cyc();
        end

        repeat (4) cyc();
        check("issue_count", issues, closes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
